// File: rtl/frame_injector_mp.sv
// Button-driven frame injector: queues send requests and launches them per port.
// Optional `FRAME_INJ_DEBOUNCE_EN adds a button debounce filter.
module frame_injector_mp #(
  parameter int              NUM_PORTS    = 4,
  parameter int              ADDR_W       = 4,
  parameter int              PAYLOAD_W    = 4,
  parameter int              FIFO_DEPTH   = 4,
  parameter logic [ADDR_W-1:0] MAC_BASE   = 4'hA,
  parameter logic [3:0]      SFD          = 4'b0101,
  parameter int              TIMEOUT_CYC  = 1024,
  parameter int              DEBOUNCE_CYC = 16,
  localparam int FRAME_W = 4 + 2*ADDR_W + PAYLOAD_W,
  localparam int CW      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 send_btn,
  input  logic [ADDR_W-1:0]    dst_addr,
  input  logic [ADDR_W-1:0]    src_addr,
  input  logic [PAYLOAD_W-1:0] payload,
  input  logic [NUM_PORTS-1:0] tx_busy,
  input  logic [NUM_PORTS-1:0] rx_valid,
  output logic [FRAME_W-1:0]   tx_frame,
  output logic [NUM_PORTS-1:0] tx_valid,
  output logic [NUM_PORTS-1:0] rx_flags,
  output logic [7:0]           rx_count,
  output logic [CW-1:0]        fifo_count,
  output logic                 drop_pulse,
  output logic                 timeout_pulse,
  output logic                 busy
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;

  logic btn_f;

`ifdef FRAME_INJ_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  logic          filt_q;
  logic [DW-1:0] dcnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q <= 1'b0;
      dcnt_q <= '0;
    end else if (send_btn == filt_q) begin
      dcnt_q <= '0;
    end else if (dcnt_q == DW'(DEBOUNCE_CYC - 1)) begin
      filt_q <= send_btn;
      dcnt_q <= '0;
    end else begin
      dcnt_q <= dcnt_q + 1'b1;
    end
  end

  assign btn_f = filt_q;
`else
  assign btn_f = send_btn;
`endif

  state_t               state_q, state_d;
  logic                 btn_prev_q;
  logic [NUM_PORTS-1:0] rx_prev_q, rise;
  logic [PW-1:0]        port_mem [FIFO_DEPTH];
  logic [FRAME_W-1:0]   frm_mem  [FIFO_DEPTH];
  logic [AW-1:0]        wp_q, rp_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [FRAME_W-1:0]   tx_frame_q, tx_frame_d;
  logic [NUM_PORTS-1:0] tx_valid_q, tx_valid_d;
  logic [NUM_PORTS-1:0] flags_q, flags_d;
  logic [7:0]           rxc_q, rxc_d;
  logic                 drop_q, drop_d, to_q, to_d;
  logic                 send_ev, mapped, full, push, pop;
  logic [ADDR_W-1:0]    src_off;
  logic [PW-1:0]        hp;
  logic [8:0]           sum;

  assign send_ev = btn_f & ~btn_prev_q;
  assign src_off = src_addr - MAC_BASE;
  assign mapped  = 32'(src_off) < 32'(NUM_PORTS);
  assign full    = cnt_q == CW'(FIFO_DEPTH);
  assign push    = send_ev & mapped & ~full;
  assign pop     = state_q == LAUNCH;
  assign drop_d  = send_ev & (full | ~mapped);
  assign cnt_d   = cnt_q + CW'(push) - CW'(pop);
  assign rise    = rx_valid & ~rx_prev_q;
  assign hp      = port_mem[rp_q];

  always_ff @(posedge clk) begin
    if (push) begin
      port_mem[wp_q] <= PW'(src_off);
      frm_mem[wp_q]  <= {SFD, dst_addr, src_addr, payload};
    end
  end

  always_comb begin
    state_d    = state_q;
    tx_valid_d = '0;
    tx_frame_d = tx_frame_q;
    timer_d    = timer_q;
    to_d       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cnt_q != '0 && !tx_busy[hp]) begin
          state_d    = LAUNCH;
          tx_valid_d = NUM_PORTS'(1) << hp;
          tx_frame_d = frm_mem[rp_q];
        end
      end
      LAUNCH: begin
        state_d = WAIT;
        timer_d = '0;
      end
      WAIT: begin
        // A delivery that rose during LAUNCH survives only in the flags.
        if (|rise || |flags_q) begin
          state_d = IDLE;
        end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
          state_d = IDLE;
          to_d    = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    flags_d = (pop ? '0 : flags_q) | rise;
    sum     = {1'b0, rxc_q};
    for (int i = 0; i < NUM_PORTS; i++) sum = sum + 9'(rise[i]);
    rxc_d   = (sum > 9'd255) ? 8'd255 : sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      btn_prev_q <= 1'b0;
      rx_prev_q  <= '0;
      wp_q       <= '0;
      rp_q       <= '0;
      cnt_q      <= '0;
      timer_q    <= '0;
      tx_frame_q <= '0;
      tx_valid_q <= '0;
      flags_q    <= '0;
      rxc_q      <= '0;
      drop_q     <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      btn_prev_q <= btn_f;
      rx_prev_q  <= rx_valid;
      wp_q       <= wp_q + AW'(push);
      rp_q       <= rp_q + AW'(pop);
      cnt_q      <= cnt_d;
      timer_q    <= timer_d;
      tx_frame_q <= tx_frame_d;
      tx_valid_q <= tx_valid_d;
      flags_q    <= flags_d;
      rxc_q      <= rxc_d;
      drop_q     <= drop_d;
      to_q       <= to_d;
    end
  end

  assign tx_frame      = tx_frame_q;
  assign tx_valid      = tx_valid_q;
  assign rx_flags      = flags_q;
  assign rx_count      = rxc_q;
  assign fifo_count    = cnt_q;
  assign drop_pulse    = drop_q;
  assign timeout_pulse = to_q;
  assign busy          = state_q != IDLE;

endmodule

// File: tb/tb_frame_injector_mp.sv
// Scoreboard bench for frame_injector_mp: launches queued as expected,
// a negedge monitor pops and compares each tx_valid strobe.
module tb_frame_injector_mp;

  logic        clk = 0;
  logic        rst;
  logic        send_btn;
  logic [3:0]  dst_addr, src_addr, payload;
  logic [3:0]  tx_busy, rx_valid, rx_force, ack_q;
  logic [15:0] tx_frame;
  logic [3:0]  tx_valid, rx_flags;
  logic [7:0]  rx_count;
  logic [2:0]  fifo_count;
  logic        drop_pulse, timeout_pulse, busy;

  frame_injector_mp dut (
    .clk(clk), .rst(rst), .send_btn(send_btn),
    .dst_addr(dst_addr), .src_addr(src_addr), .payload(payload),
    .tx_busy(tx_busy), .rx_valid(rx_valid),
    .tx_frame(tx_frame), .tx_valid(tx_valid), .rx_flags(rx_flags),
    .rx_count(rx_count), .fifo_count(fifo_count),
    .drop_pulse(drop_pulse), .timeout_pulse(timeout_pulse), .busy(busy)
  );

  always #5 clk = ~clk;

`ifdef FRAME_INJ_DEBOUNCE_EN
  localparam int HOLD = 20;
`else
  localparam int HOLD = 2;
`endif

  int          n_pass = 0, n_total = 0;
  logic [19:0] exp_q[$];
  int          drop_seen = 0, exp_drop = 0;
  int          cyc = 0, t_launch = 0;
  int          exp_rx = 0;
  logic [3:0]  rxp;
  bit          auto_ack = 0;

  assign rx_valid = rx_force | ack_q;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      exp_rx = 0;
      rxp    = '0;
    end else begin
      exp_rx = exp_rx + $countones(rx_valid & ~rxp);
      if (exp_rx > 255) exp_rx = 255;
      rxp = rx_valid;
    end
  end

  initial begin
    ack_q = '0;
    forever begin
      @(negedge clk);
      ack_q = auto_ack ? tx_valid : '0;
    end
  end

  initial forever begin
    logic [19:0] e;
    @(negedge clk);
    if (tx_valid != '0) begin
      t_launch = cyc;
      if (exp_q.size() == 0) begin
        chk("unexpected_launch", tx_valid, 0);
      end else begin
        e = exp_q.pop_front();
        chk("launch_port", tx_valid, e[19:16]);
        chk("launch_frame", tx_frame, e[15:0]);
      end
    end
    if (drop_pulse) drop_seen++;
  end

  task automatic press(input logic [3:0] s, d, p);
    src_addr = s; dst_addr = d; payload = p;
    send_btn = 1;
    repeat (HOLD) @(negedge clk);
    send_btn = 0;
    repeat (HOLD) @(negedge clk);
  endtask

  task automatic wait_idle(string name, int limit);
    int k;
    for (k = 0; k < limit; k++) begin
      @(negedge clk);
      if (!busy && fifo_count == 0) break;
    end
    chk(name, k < limit, 1);
  endtask

  initial begin
    int k;
    rst = 1; send_btn = 0; dst_addr = 0; src_addr = 0; payload = 0;
    tx_busy = 0; rx_force = 0;
    repeat (3) @(negedge clk);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rx_flags", rx_flags, 0);
    chk("rst_rx_count", rx_count, 0);
    chk("rst_tx_frame", tx_frame, 0);
    rst = 0;
    @(negedge clk);

    // single press, minimum latency
    auto_ack = 1;
    exp_q.push_back({4'b0001, 16'h5CA5});
`ifdef FRAME_INJ_DEBOUNCE_EN
    press(4'hA, 4'hC, 4'h5);
`else
    src_addr = 4'hA; dst_addr = 4'hC; payload = 4'h5;
    send_btn = 1;
    @(negedge clk);
    chk("lat_early_tx", tx_valid, 0);
    chk("lat_fifo_count", fifo_count, 1);
    @(negedge clk);
    chk("lat_tx_valid", tx_valid, 4'b0001);
    send_btn = 0;
`endif
    wait_idle("single_idle", 50);
    chk("single_rx_count", rx_count, exp_rx);

    // fill the queue while port 0 is busy, overflow once
    tx_busy = 4'b0001;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q.push_back({4'b0001, 4'h5, 4'h6, 4'hA, 4'(i)});
      else exp_drop++;
      press(4'hA, 4'h6, 4'(i));
    end
    @(negedge clk);
    chk("full_fifo_count", fifo_count, 4);
    chk("full_drop", drop_seen, exp_drop);
    chk("full_busy", busy, 0);
    tx_busy = 0;
    wait_idle("drain_idle", 200);
    chk("drain_rx_count", rx_count, exp_rx);

    // unmapped source
    exp_drop++;
    press(4'h3, 4'hC, 4'h7);
    repeat (3) @(negedge clk);
    chk("unmapped_fifo", fifo_count, 0);
    chk("unmapped_busy", busy, 0);
    chk("unmapped_drop", drop_seen, exp_drop);

    // timeout: 1 LAUNCH cycle + 1024 WAIT cycles
    auto_ack = 0;
    exp_q.push_back({4'b0010, 16'h5CB9});
    press(4'hB, 4'hC, 4'h9);
    for (k = 0; k < 1200; k++) begin
      @(negedge clk);
      if (timeout_pulse) break;
    end
    chk("timeout_seen", k < 1200, 1);
    chk("timeout_delay", cyc - t_launch, 1025);
    chk("timeout_busy", busy, 0);
    chk("timeout_flags", rx_flags, 0);
    @(negedge clk);
    chk("timeout_single", timeout_pulse, 0);

    // delivery rising during LAUNCH
    exp_q.push_back({4'b1000, 16'h51D2});
    src_addr = 4'hD; dst_addr = 4'h1; payload = 4'h2;
    send_btn = 1;
    for (k = 0; k < 60; k++) begin
      @(negedge clk);
      if (tx_valid != 0) break;
    end
    chk("launch_seen", k < 60, 1);
    rx_force = 4'b0100;
    @(negedge clk);
    chk("launch_rx_flags", rx_flags, 4'b0100);
    chk("launch_rx_count", rx_count, exp_rx);
    for (k = 0; k < 3; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("launch_idle", k < 3, 1);
    send_btn = 0;
    rx_force = 0;
    repeat (HOLD) @(negedge clk);

    // reset discards queued requests
    tx_busy = 4'b0001;
    press(4'hA, 4'h2, 4'h3);
    chk("pre_rst_fifo", fifo_count, 1);
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    tx_busy = 0;
    repeat (10) @(negedge clk);
    chk("post_rst_fifo", fifo_count, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_rx_count", rx_count, exp_rx);

`ifdef FRAME_INJ_DEBOUNCE_EN
    src_addr = 4'hA; dst_addr = 4'h4; payload = 4'h8;
    send_btn = 1;
    repeat (5) @(negedge clk);
    send_btn = 0;
    repeat (30) @(negedge clk);
    chk("glitch_fifo", fifo_count, 0);
    chk("glitch_busy", busy, 0);
    auto_ack = 1;
    exp_q.push_back({4'b0001, 16'h54A8});
    send_btn = 1;
    repeat (20) @(negedge clk);
    send_btn = 0;
    repeat (20) @(negedge clk);
    wait_idle("debounce_idle", 50);
`endif

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("drop_total", drop_seen, exp_drop);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
